id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter CTRL_W, default 8: width of the decoded control bundle carried to EX.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  hold all stage contents this cycle.
REQ-005 flush  input  1  replace stage contents with a bubble this cycle.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_pc  input  32  instruction PC.
REQ-008 id_a, id_b  input  32 each  register-file read data (ALU operands a, b).
REQ-009 id_imm  input  16  raw instruction immediate field.
REQ-010 id_ext_op  input  2  extension mode: 00 zero, 01 sign, 10 upper (LUI), 11 reserved.
REQ-011 id_shamt  input  5  shift amount field.
REQ-012 id_rd  input  5  destination register number.
REQ-013 id_ctrl  input  CTRL_W  decoded ALU/memory/writeback controls.
REQ-014 ex_valid, ex_pc, ex_a, ex_b, ex_shamt, ex_rd, ex_ctrl  output  widths as inputs  registered copies for EX.
REQ-015 ex_imm  output  32  registered extended immediate, fed to ALU in/b-mux.
REQ-016 bubble_cnt  output  16  count of flush-inserted bubbles.

Function
REQ-017 Immediate extension SHALL be computed combinationally from id_imm/id_ext_op and registered into ex_imm: 00 -> {16'h0000, imm}; 01 -> {16{imm[15]}, imm}; 10 -> per REQ-031/032; 11 -> same as 00.
REQ-018 Update priority per rising edge SHALL be rst > flush > stall > load.
REQ-019 Load (no rst, flush, stall): every ex_* output SHALL take its id_* source (ex_imm the extended value) one cycle later; latency exactly 1 cycle.
REQ-020 Data fields SHALL be captured on load even when id_valid=0; ex_valid SHALL equal the loaded id_valid.
REQ-021 Stall (flush=0): all ex_* outputs and bubble_cnt SHALL hold their previous values.
REQ-022 Flush SHALL set ex_valid=0, ex_ctrl=0, ex_rd=0, and ex_pc, ex_a, ex_b, ex_imm, ex_shamt to 0, regardless of stall.
REQ-023 Flush and stall asserted together: flush SHALL win (bubble inserted, not hold).
REQ-024 bubble_cnt SHALL increment by 1 on each edge where flush=1 and rst=0, independent of stall and id_valid.
REQ-025 bubble_cnt SHALL saturate at 16'hFFFF (no wrap).
REQ-026 No output SHALL depend combinationally on any input; all outputs are flop outputs.

Reset
REQ-027 On a rising edge with rst=1, all ex_* outputs SHALL become 0 and bubble_cnt SHALL become 0.
REQ-028 rst SHALL override flush and stall in the same cycle; no increment of bubble_cnt.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction; first edge after rst deasserts performs normal priority evaluation.
REQ-030 No asynchronous reset path SHALL exist.

Configuration
REQ-031 With macro ID_EX_LUI_EN defined: id_ext_op=10 SHALL produce ex_imm = {imm, 16'h0000}.
REQ-032 Without ID_EX_LUI_EN: id_ext_op=10 SHALL behave as 00 (zero extension); port list unchanged.

Verification
REQ-033 rst=1 one edge with all inputs nonzero -> all outputs 0, bubble_cnt=0.
REQ-034 Load id_imm=16'h8001, ext_op=01, id_a=32'h12345678, id_valid=1 -> next cycle ex_imm=32'hFFFF8001, ex_a=32'h12345678, ex_valid=1; ext_op=00 -> 32'h00008001.
REQ-035 Load ex_rd=5'd9, then stall=1 for 3 cycles with id_rd=5'd3 -> ex_rd stays 9, bubble_cnt unchanged; stall=0 -> ex_rd=3.
REQ-036 stall=1 and flush=1 same edge with ex_valid=1 -> ex_valid=0, ex_ctrl=0, ex_rd=0, bubble_cnt +1.
REQ-037 Preload bubble_cnt to 16'hFFFE via repeated flush, flush 3 more edges -> bubble_cnt=16'hFFFF, stays.
REQ-038 id_imm=16'h00AB, ext_op=10: with ID_EX_LUI_EN -> ex_imm=32'h00AB0000; without -> 32'h000000AB.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: stall/flush control, immediate extension, saturating bubble counter.
// Define ID_EX_LUI_EN to make id_ext_op=2'b10 place the immediate in the upper half (LUI).
module id_ex_reg #(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_a,
    input  logic [31:0]       id_b,
    input  logic [15:0]       id_imm,
    input  logic [1:0]        id_ext_op,
    input  logic [4:0]        id_shamt,
    input  logic [4:0]        id_rd,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_shamt,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [15:0]       bubble_cnt
);

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_RSVD  = 2'b11
    } ext_op_e;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       a;
        logic [31:0]       b;
        logic [31:0]       imm;
        logic [4:0]        shamt;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } stage_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    stage_t      stage_q, stage_d, stage_load;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] imm_ext;

    // NOTE: every variable assigned in always_comb gets a value on every path
    // (default first), otherwise synthesis infers a latch.
    always_comb begin
        imm_ext = {16'h0000, id_imm};
        case (ext_op_e'(id_ext_op))
            EXT_SIGN:  imm_ext = {{16{id_imm[15]}}, id_imm};
`ifdef ID_EX_LUI_EN
            EXT_UPPER: imm_ext = {id_imm, 16'h0000};
`else
            EXT_UPPER: imm_ext = {16'h0000, id_imm};
`endif
            default:   imm_ext = {16'h0000, id_imm};
        endcase
    end

    always_comb begin
        stage_load.valid = id_valid;
        stage_load.pc    = id_pc;
        stage_load.a     = id_a;
        stage_load.b     = id_b;
        stage_load.imm   = imm_ext;
        stage_load.shamt = id_shamt;
        stage_load.rd    = id_rd;
        stage_load.ctrl  = id_ctrl;
    end

    // Flush beats stall: a bubble is inserted even while the stage is held.
    always_comb begin
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            stage_d = '0;
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end else if (!stall) begin
            stage_d = stage_load;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; reset is synchronous, so it only acts on a clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = stage_q.valid;
    assign ex_pc      = stage_q.pc;
    assign ex_a       = stage_q.a;
    assign ex_b       = stage_q.b;
    assign ex_imm     = stage_q.imm;
    assign ex_shamt   = stage_q.shamt;
    assign ex_rd      = stage_q.rd;
    assign ex_ctrl    = stage_q.ctrl;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: the driver pushes model predictions, a monitor pops and compares.
// Build with +define+ID_EX_LUI_EN to exercise the LUI variant of the immediate extension.
module tb_id_ex_reg;

    localparam int CTRL_W = 8;

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       a;
        logic [31:0]       b;
        logic [31:0]       imm;
        logic [4:0]        shamt;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
        logic [15:0]       cnt;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst, stall, flush, id_valid;
    logic [31:0]       id_pc, id_a, id_b;
    logic [15:0]       id_imm;
    logic [1:0]        id_ext_op;
    logic [4:0]        id_shamt, id_rd;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_valid;
    logic [31:0]       ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]        ex_shamt, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [15:0]       bubble_cnt;

    int checks = 0;
    int errors = 0;

    obs_t  exp_q[$];
    string tag_q[$];
    obs_t  model;

    always #5 clk = ~clk;

    id_ex_reg #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_a(id_a), .id_b(id_b),
        .id_imm(id_imm), .id_ext_op(id_ext_op), .id_shamt(id_shamt),
        .id_rd(id_rd), .id_ctrl(id_ctrl),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_shamt(ex_shamt), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
    );

    // Reference immediate: numeric value of the 16-bit field, shifted or sign-adjusted.
    function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] op);
        logic [31:0] v;
        v = 32'(imm);
        if (op == 2'd1 && imm >= 16'h8000) v = v + 32'hFFFF_0000;
`ifdef ID_EX_LUI_EN
        if (op == 2'd2) v = v * 32'd65536;
`endif
        return v;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got v=%0b pc=%h a=%h b=%h imm=%h sh=%0d rd=%0d ctrl=%h cnt=%h, expected v=%0b pc=%h a=%h b=%h imm=%h sh=%0d rd=%0d ctrl=%h cnt=%h",
                     name, act.valid, act.pc, act.a, act.b, act.imm, act.shamt, act.rd, act.ctrl, act.cnt,
                     exp.valid, exp.pc, exp.a, exp.b, exp.imm, exp.shamt, exp.rd, exp.ctrl, exp.cnt);
        end
    endtask

    // Apply the stage rules (reset, then flush, then stall, else load) to the model
    // for the edge that follows, queue the prediction, and wait one cycle.
    task automatic step(input string tag);
        if (rst) begin
            model = '0;
        end else if (flush) begin
            model = {1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, {CTRL_W{1'b0}},
                     (model.cnt == 16'hFFFF) ? model.cnt : model.cnt + 16'd1};
        end else if (!stall) begin
            model.valid = id_valid;
            model.pc    = id_pc;
            model.a     = id_a;
            model.b     = id_b;
            model.imm   = ext_model(id_imm, id_ext_op);
            model.shamt = id_shamt;
            model.rd    = id_rd;
            model.ctrl  = id_ctrl;
        end
        exp_q.push_back(model);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    task automatic randomize_fields();
        id_valid  = 1'($urandom);
        id_pc     = $urandom;
        id_a      = $urandom;
        id_b      = $urandom;
        id_imm    = 16'($urandom);
        id_ext_op = 2'($urandom);
        id_shamt  = 5'($urandom);
        id_rd     = 5'($urandom);
        id_ctrl   = CTRL_W'($urandom);
    endtask

    // Monitor: the register presents a result every cycle, sampled 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                check(tag_q.pop_front(),
                      {ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_shamt, ex_rd, ex_ctrl, bubble_cnt},
                      exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached with %0d predictions pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        model = '0;
        // Reset with every input nonzero, including flush and stall.
        rst = 1'b1; flush = 1'b1; stall = 1'b1;
        id_valid = 1'b1; id_pc = 32'hFFFF_FFFF; id_a = 32'hA5A5_A5A5; id_b = 32'h5A5A_5A5A;
        id_imm = 16'hFFFF; id_ext_op = 2'd1; id_shamt = 5'd31; id_rd = 5'd31; id_ctrl = '1;
        step("reset_all_nonzero");
        step("reset_hold");

        // Sign and zero extension loads.
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        id_imm = 16'h8001; id_ext_op = 2'd1; id_a = 32'h1234_5678; id_valid = 1'b1;
        step("load_sign_ext");
        id_ext_op = 2'd0;
        step("load_zero_ext");
        id_ext_op = 2'd3;
        step("load_reserved_ext");
        id_valid = 1'b0;
        step("load_invalid_data");

        // Hold through a three-cycle stall, then release.
        id_valid = 1'b1; id_rd = 5'd9;
        step("load_rd9");
        stall = 1'b1; id_rd = 5'd3;
        repeat (3) step("stall_hold_rd9");
        stall = 1'b0;
        step("release_rd3");

        // Flush wins over stall.
        stall = 1'b1; flush = 1'b1;
        step("flush_over_stall");
        stall = 1'b0; flush = 1'b0;

        // Upper-immediate extension mode.
        id_imm = 16'h00AB; id_ext_op = 2'd2;
        step("ext_upper_mode");

        // Reset in the middle of a stall discards the held instruction.
        randomize_fields();
        step("load_before_stall");
        stall = 1'b1;
        step("stall_before_reset");
        rst = 1'b1;
        step("reset_mid_stall");
        rst = 1'b0;
        step("stall_after_reset");
        stall = 1'b0;
        step("load_after_reset");

        // Random mix of reset, flush, stall and load.
        for (int i = 0; i < 2000; i++) begin
            randomize_fields();
            rst   = ($urandom_range(0, 99) < 3);
            flush = ($urandom_range(0, 99) < 15);
            stall = ($urandom_range(0, 99) < 30);
            step("random");
        end

        // Drive the bubble counter to FFFE, then into saturation.
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        step("reset_before_saturation");
        rst = 1'b0; flush = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            stall    = 1'($urandom);
            id_valid = 1'($urandom);
            step("flush_count_up");
        end
        repeat (3) step("flush_saturate");
        flush = 1'b0; stall = 1'b0;
        randomize_fields();
        step("load_keeps_saturated_cnt");

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
